// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the write port of a flagless FIFO between two
// producers, sequences single-consumer reads, tracks occupancy and drains
// the FIFO on a flush request.
//
// Optional feature macro: FIFO_ARB_FIXED_PRIO_EN
//   defined   -> producer A always wins a simultaneous request.
//   undefined -> round-robin tie-break on the last winner (default).
//
// state    | meaning
// ST_RUN   | normal operation: arbitrate writes, serve pops, track COUNT
// ST_FLUSH | drain: one read per cycle until COUNT is 0, no grants, POP ignored

module fifo_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_a_i,
  input  logic              req_b_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  output logic              gnt_a_o,
  output logic              gnt_b_o,
  input  logic              pop_i,
  output logic              pop_ack_o,
  input  logic              flush_i,
  output logic              wen_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              ren_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t              state_q, state_d;
  logic                gnt_a_q, gnt_a_d;
  logic                gnt_b_q, gnt_b_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ren_q, ren_d;
  logic                pop_ack_q, pop_ack_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                wr_room;
  logic                rd_avail;
  logic                pick_a;
  logic                pick_b;
  logic                do_wr;
  logic                do_rd;

  // Eligibility uses the pre-edge count only; a same-cycle pop never frees
  // a slot and a same-cycle write never makes an empty FIFO poppable.
  assign wr_room  = (count_q < DEPTH_C);
  assign rd_avail = (count_q != '0);

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign pick_a = wr_room && req_a_i;
`else
  // last_q: 1 = B won most recently, so A takes the next tie.
  logic last_q, last_d;
  assign pick_a = wr_room && req_a_i && (!req_b_i || last_q);
`endif
  assign pick_b = wr_room && req_b_i && !pick_a;

  assign do_wr = pick_a || pick_b;
  assign do_rd = pop_i && rd_avail;

  // Next-state and next-output computation for both states.
  always_comb begin
    state_d   = state_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    ren_d     = 1'b0;
    pop_ack_d = 1'b0;
    count_d   = count_q;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (pick_a) begin
          gnt_a_d = 1'b1;
          wen_d   = 1'b1;
          wdata_d = data_a_i;
`ifndef FIFO_ARB_FIXED_PRIO_EN
          last_d  = 1'b0;
`endif
        end else if (pick_b) begin
          gnt_b_d = 1'b1;
          wen_d   = 1'b1;
          wdata_d = data_b_i;
`ifndef FIFO_ARB_FIXED_PRIO_EN
          last_d  = 1'b1;
`endif
        end
        if (do_rd) begin
          ren_d     = 1'b1;
          pop_ack_d = 1'b1;
        end
        count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        if (flush_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (rd_avail) begin
          ren_d   = 1'b1;
          count_d = count_q - 1'b1;
        end
        // Leave when already empty or when this edge takes the last word.
        if (count_q <= CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and registered outputs; async reset abandons FIFO contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      ren_q     <= 1'b0;
      pop_ack_q <= 1'b0;
      count_q   <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      ren_q     <= ren_d;
      pop_ack_q <= pop_ack_d;
      count_q   <= count_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign gnt_a_o      = gnt_a_q;
  assign gnt_b_o      = gnt_b_q;
  assign wen_o        = wen_q;
  assign write_data_o = wdata_q;
  assign ren_o        = ren_q;
  assign pop_ack_o    = pop_ack_q;
  assign count_o      = count_q;
  assign full_o       = (count_q == DEPTH_C);
  assign empty_o      = (count_q == '0);
  assign busy_o       = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed vector table, hand-written corner
// sequences (full, empty, flush, async reset) and random traffic against a
// queue-based reference model.

module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, pop = 1'b0, flush = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       gnt_a, gnt_b, pop_ack, wen, ren, full, empty, busy;
  logic [7:0] wdata;
  logic [3:0] count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .req_b_i(req_b),
    .data_a_i(data_a), .data_b_i(data_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b),
    .pop_i(pop), .pop_ack_o(pop_ack), .flush_i(flush),
    .wen_o(wen), .write_data_o(wdata), .ren_o(ren),
    .count_o(count), .full_o(full), .empty_o(empty), .busy_o(busy)
  );

  // {ga, gb, wen, wdata, ren, pop_ack, count, full, empty, busy}
  wire [19:0] obs = {gnt_a, gnt_b, wen, wdata, ren, pop_ack, count, full, empty, busy};

  function automatic logic [19:0] mk(input logic ga, input logic gb, input logic w,
                                     input logic [7:0] wd, input logic r, input logic pa,
                                     input int cnt, input logic bsy);
    logic [3:0] c;
    c = 4'(cnt);
    return {ga, gb, w, wd, r, pa, c, (cnt == 8), (cnt == 0), bsy};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    req_a = 0; req_b = 0; pop = 0; flush = 0; data_a = '0; data_b = '0;
  endtask

  task automatic do_reset;
    clr_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  logic       m_busy, m_last_b, m_ga, m_gb, m_wen, m_ren, m_pack;
  logic [7:0] m_wd;

  task automatic model_reset;
    m_q.delete();
    m_busy = 0; m_last_b = 1; m_wd = '0;
    m_ga = 0; m_gb = 0; m_wen = 0; m_ren = 0; m_pack = 0;
  endtask

  task automatic model_step;
    int winner;  // 0 none, 1 A, 2 B
    int sz;
    m_ga = 0; m_gb = 0; m_wen = 0; m_ren = 0; m_pack = 0;
    sz = m_q.size();
    winner = 0;
    if (!m_busy) begin
      if (sz < 8) begin
        if (req_a && req_b) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
          winner = 1;
`else
          winner = m_last_b ? 1 : 2;
`endif
        end else if (req_a) winner = 1;
        else if (req_b) winner = 2;
      end
      if (pop && sz > 0) begin
        void'(m_q.pop_front());
        m_ren = 1; m_pack = 1;
      end
      if (winner == 1) begin
        m_q.push_back(data_a); m_wd = data_a; m_ga = 1; m_wen = 1; m_last_b = 0;
      end else if (winner == 2) begin
        m_q.push_back(data_b); m_wd = data_b; m_gb = 1; m_wen = 1; m_last_b = 1;
      end
      if (flush) m_busy = 1;
    end else begin
      if (sz > 0) begin
        void'(m_q.pop_front());
        m_ren = 1;
      end
      if (m_q.size() == 0) m_busy = 0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       ra, rb;
    logic [7:0] da, db;
    logic       pop, fl;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int busy_cnt, ren_cnt, first_gnt, gnt_in_busy;
    logic [7:0] wd_hold;

    // tie sequence expectations depend on the tie-break mode
`ifdef FIFO_ARB_FIXED_PRIO_EN
    tbl[1] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(1, 0, 1, 8'hAA, 0, 0, 1, 0)};
    tbl[2] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(1, 0, 1, 8'hAA, 0, 0, 2, 0)};
    tbl[3] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(1, 0, 1, 8'hAA, 0, 0, 3, 0)};
    tbl[4] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(1, 0, 1, 8'hAA, 0, 0, 4, 0)};
    wd_hold = 8'hAA;
`else
    tbl[1] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(1, 0, 1, 8'hAA, 0, 0, 1, 0)};
    tbl[2] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(0, 1, 1, 8'h55, 0, 0, 2, 0)};
    tbl[3] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(1, 0, 1, 8'hAA, 0, 0, 3, 0)};
    tbl[4] = '{1, 1, 8'hAA, 8'h55, 0, 0, mk(0, 1, 1, 8'h55, 0, 0, 4, 0)};
    wd_hold = 8'h55;
`endif
    tbl[0] = '{0, 0, 8'h00, 8'h00, 0, 0, mk(0, 0, 0, 8'h00, 0, 0, 0, 0)};
    tbl[5] = '{0, 0, 8'h00, 8'h00, 1, 0, mk(0, 0, 0, wd_hold, 1, 1, 3, 0)};
    tbl[6] = '{1, 0, 8'hF0, 8'h00, 1, 0, mk(1, 0, 1, 8'hF0, 1, 1, 3, 0)};
    tbl[7] = '{0, 0, 8'h00, 8'h00, 0, 0, mk(0, 0, 0, 8'hF0, 0, 0, 3, 0)};

    // reset state, then a single A write of F0
    do_reset();
    check("reset_state", obs, mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
    req_a = 1; data_a = 8'hF0;
    tick();
    check("first_write_F0", obs, mk(1, 0, 1, 8'hF0, 0, 0, 1, 0));

    // table from a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_a = tbl[i].ra; req_b = tbl[i].rb; data_a = tbl[i].da; data_b = tbl[i].db;
      pop = tbl[i].pop; flush = tbl[i].fl;
      tick();
      check($sformatf("table_%0d", i), obs, tbl[i].exp);
    end

    // full: 8 writes, blocked B, then pop + B, then B lands
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_a = 1; data_a = 8'(i);
      tick();
    end
    req_a = 0; req_b = 1; data_b = 8'h99;
    tick();
    check("full_blocks_b", obs, mk(0, 0, 0, 8'h07, 0, 0, 8, 0));
    pop = 1;
    tick();
    check("full_pop_no_slot", obs, mk(0, 0, 0, 8'h07, 1, 1, 7, 0));
    pop = 0;
    tick();
    check("full_b_after_pop", obs, mk(0, 1, 1, 8'h99, 0, 0, 8, 0));

    // empty: pop with write in same cycle is refused
    do_reset();
    pop = 1; req_a = 1; data_a = 8'h3C;
    tick();
    check("empty_pop_write", obs, mk(1, 0, 1, 8'h3C, 0, 0, 1, 0));

    // flush of 5 words with A waiting
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_a = 1; data_a = 8'(i + 1);
      tick();
    end
    req_a = 0; flush = 1;
    tick();
    check("flush_entry", obs, mk(0, 0, 0, 8'h05, 0, 0, 5, 1));
    flush = 0; req_a = 1; data_a = 8'h77;
    busy_cnt = int'(busy); ren_cnt = int'(ren); first_gnt = -1; gnt_in_busy = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      busy_cnt += int'(busy);
      ren_cnt  += int'(ren);
      if (gnt_a && busy) gnt_in_busy++;
      if (gnt_a && first_gnt < 0) first_gnt = j;
      if (j == 5) check_int("flush_count_zero", int'(count), 0);
      if (gnt_a) req_a = 0;
    end
    check_int("flush_busy_cycles", busy_cnt, 5);
    check_int("flush_ren_cycles", ren_cnt, 5);
    check_int("flush_no_grant", gnt_in_busy, 0);
    check_int("flush_first_grant", first_gnt, 6);

    // flush with empty FIFO: one busy cycle, no reads
    do_reset();
    flush = 1;
    tick();
    flush = 0;
    check("flush_empty_busy", obs, mk(0, 0, 0, 8'h00, 0, 0, 0, 1));
    tick();
    check("flush_empty_done", obs, mk(0, 0, 0, 8'h00, 0, 0, 0, 0));

    // async reset mid-cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_a = 1; data_a = 8'hC0 + 8'(i);
      tick();
    end
    check("pre_async_rst", obs, mk(1, 0, 1, 8'hC2, 0, 0, 3, 0));
    #2 rst = 1;
    #1 check("async_rst", obs, mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
    clr_inputs();
    @(posedge clk);
    #1 rst = 0;

    // random traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!req_a || m_ga) begin
        req_a = ($urandom_range(0, 9) < 6);
        data_a = 8'($urandom);
      end
      if (!req_b || m_gb) begin
        req_b = ($urandom_range(0, 9) < 6);
        data_b = 8'($urandom);
      end
      pop = $urandom_range(0, 1) == 1;
      flush = ($urandom_range(0, 39) == 0);
      model_step();
      tick();
      check($sformatf("rand_%0d", c), obs,
            mk(m_ga, m_gb, m_wen, m_wd, m_ren, m_pack, m_q.size(), m_busy));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Controller that shares the single write port of the 8-bit FIFO between two producers (A, B) and sequences its read port for one consumer. The FIFO exposes no flags, so this block keeps the authoritative occupancy count, refuses writes when full and reads when empty, and supports a flush that drains the FIFO. It sits directly in front of the FIFO, driving its WEN, WriteData and REN.

## Interface
- DATA_W, 8: data width; matches the FIFO word.
- DEPTH, 8: FIFO capacity in words.
- CNT_W, 4: COUNT width; must hold DEPTH.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_A / REQ_B  in  1  producer write request; held until granted.
- DATA_A / DATA_B  in  DATA_W  producer data; stable while REQ is high.
- GNT_A / GNT_B  out  1  one-cycle grant; the word was written at this edge.
- POP  in  1  consumer read request.
- POP_ACK  out  1  one-cycle acknowledge; mirrors REN.
- FLUSH  in  1  pulse; starts a drain of the FIFO.
- WEN  out  1  to FIFO write enable.
- WriteData  out  DATA_W  to FIFO write data.
- REN  out  1  to FIFO read enable.
- COUNT  out  CNT_W  occupancy, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH; combinational from COUNT.
- EMPTY  out  1  COUNT == 0; combinational from COUNT.
- BUSY  out  1  high while in state FLUSH.

## Operation
- Reset values: GNT_A=GNT_B=0, WEN=0, REN=0, POP_ACK=0, WriteData=0, COUNT=0, EMPTY=1, FULL=0, BUSY=0, state RUN, round-robin pointer LAST=B (so A wins the first tie).
- State RUN, evaluated at each edge:
  - Write eligibility requires COUNT < DEPTH, using the pre-edge COUNT. A pop in the same cycle does not free a slot for a write.
  - Winner: the single requester if only one asserts REQ. On a tie, the requester other than LAST wins.
  - On a win: WriteData <= winner's DATA, WEN <= 1, GNT_winner <= 1, LAST <= winner. Otherwise WEN and both GNTs go to 0.
  - Pop eligibility requires POP && COUNT > 0. A write in the same cycle does not make an empty FIFO poppable.
  - On an eligible pop: REN <= 1 and POP_ACK <= 1.
  - COUNT <= COUNT + write − pop. Simultaneous write and pop leaves COUNT unchanged.
- FLUSH sampled high in RUN moves the block to FLUSH at that edge. Any write or pop granted at that same edge still completes.
- State FLUSH:
  - No grants are issued. POP is ignored.
  - REN = 1 every cycle while COUNT > 0, decrementing COUNT by 1 per cycle. POP_ACK stays 0.
  - When COUNT is 0 (or reaches 0 at this edge), return to RUN with REN = 0.
  - FLUSH asserted while already in FLUSH is ignored. FLUSH with COUNT = 0 spends one cycle in FLUSH, then returns to RUN.
- An async RST mid-operation returns every output to its reset value immediately. The FIFO contents are abandoned; COUNT=0 is authoritative.

## Timing
- Grant latency is 1 edge: REQ sampled at edge k gives GNT, WEN and WriteData high during cycle k+1.
- A requester seeing GNT high during cycle k+1 presents its next word or drops REQ before edge k+2.
- Back-to-back grants to one requester are allowed, one per cycle. With both requesting continuously, grants alternate A, B, A, B.
- Pop latency is 1 edge: REN and POP_ACK are high in the cycle after POP is sampled. ReadData timing is the FIFO's.
- FULL and EMPTY update in the same cycle as COUNT.
- Flush of N words: BUSY is high for max(N, 1) cycles, with REN high for N of them.

## Configuration
- FIFO_ARB_FIXED_PRIO_EN defined: A always wins a tie over B, and LAST is unused.
- FIFO_ARB_FIXED_PRIO_EN undefined (default): round-robin tie-break as described above.

## Test plan
- Reset, then REQ_A with DATA_A=8'hF0 for 1 cycle -> GNT_A=1, WEN=1, WriteData=8'hF0 next cycle; COUNT=1, EMPTY=0.
- REQ_A and REQ_B held for 4 cycles with DATA_A=8'hAA, DATA_B=8'h55 -> WriteData sequence AA,55,AA,55, COUNT=4. With FIFO_ARB_FIXED_PRIO_EN the sequence is AA,AA,AA,AA.
- Write 8 words, then REQ_B with 8'h99 -> FULL=1, COUNT=8, GNT_B held 0. Then POP and REQ_B together -> REN=1, GNT_B=0, COUNT=7; on the next cycle GNT_B=1, COUNT=8.
- With EMPTY=1, POP and REQ_A in the same cycle -> REN=0, POP_ACK=0, GNT_A=1, COUNT=1.
- With COUNT=5, pulse FLUSH while REQ_A is high -> BUSY=1 for 5 cycles, REN=1 for 5 cycles, no GNT_A, COUNT=0; then RUN, and GNT_A=1 on the following cycle.
- Assert RST asynchronously with COUNT=3 and WEN=1 mid-cycle -> WEN, GNTs and COUNT drop to 0 without waiting for a clock edge, and EMPTY=1.
